// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: access-size codes, handshake FSM states and the alignment rule
// shared by the LSU memory stage and its load extractor.
package lsu_mem_stage_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, ACCESS} state_e;
  // Any size code other than byte/halfword behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == F3_B[1:0]) ? 1'b0 : (size == F3_H[1:0]) ? a[0] : (a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_stage_load_ext.sv
// load_ext: picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_ext
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] value_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        uns;
  always_comb begin
    b = 8'(rdata_i >> {addr_i, 3'b000});
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    uns = (funct3_i == F3_BU) || (funct3_i == F3_HU);
    value_o = (funct3_i[1:0] == F3_B[1:0]) ? {{24{b[7] & ~uns}}, b} :
              (funct3_i[1:0] == F3_H[1:0]) ? {{16{h[15] & ~uns}}, h} : rdata_i;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: EX/MEM capture register, data-memory request/ack FSM and MEM/WB result
// register; stalls upstream while an aligned access waits for its acknowledge.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_E,
  input  logic [31:0] ALU_VAL_E,
  input  logic [31:0] STORE_VAL_E,
  input  logic        MEM_READ_E,
  input  logic        MEM_WRITE_E,
  input  logic [2:0]  FUNCT3_E,
  input  logic [4:0]  RD_E,
  input  logic        REG_WRITE_E,
  output logic        STALL_M,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_WSTRB,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] ALU_VAL_EM,
  output logic [31:0] RD_VAL_M,
  output logic [4:0]  RD_M,
  output logic        REG_WRITE_M,
  output logic        VALID_M,
  output logic        MISALIGN_M
);
  state_e      state_q, state_d;
  logic        em_valid_q, em_read_q, em_write_q, em_rw_q;
  logic [31:0] em_alu_q, em_store_q;
  logic [2:0]  em_f3_q;
  logic [4:0]  em_rd_q;
  logic        m_valid_q, m_rw_q, m_mis_q;
  logic [31:0] m_val_q;
  logic [4:0]  m_rd_q;
  logic        em_mis, m_load;
  logic [31:0] load_val;
  load_ext u_load_ext (
    .rdata_i (DMEM_RDATA),
    .addr_i  (em_alu_q[1:0]),
    .funct3_i(em_f3_q),
    .value_o (load_val)
  );
  always_comb begin
    em_mis = (em_read_q | em_write_q) & misaligned(em_f3_q[1:0], em_alu_q[1:0]);
    DMEM_REQ = state_q == ACCESS;
    STALL_M = DMEM_REQ & ~DMEM_ACK;
    m_load = em_valid_q & ~STALL_M;
    // ACCESS is entered only for an op that will actually reach memory.
    state_d = (STALL_M | (VALID_E & (MEM_READ_E | MEM_WRITE_E) &
              ~misaligned(FUNCT3_E[1:0], ALU_VAL_E[1:0]))) ? ACCESS : IDLE;
    DMEM_WE = DMEM_REQ & em_write_q;
    DMEM_ADDR = {em_alu_q[31:2], 2'b00};
    DMEM_WSTRB = !DMEM_WE ? 4'b0000 :
                 (em_f3_q[1:0] == F3_B[1:0]) ? 4'b0001 << em_alu_q[1:0] :
                 (em_f3_q[1:0] == F3_H[1:0]) ? (em_alu_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    DMEM_WDATA = (em_f3_q[1:0] == F3_B[1:0]) ? {4{em_store_q[7:0]}} :
                 (em_f3_q[1:0] == F3_H[1:0]) ? {2{em_store_q[15:0]}} : em_store_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      em_valid_q <= 1'b0;
      em_read_q  <= 1'b0;
      em_write_q <= 1'b0;
      em_rw_q    <= 1'b0;
      em_alu_q   <= '0;
      em_store_q <= '0;
      em_f3_q    <= '0;
      em_rd_q    <= '0;
      m_valid_q  <= 1'b0;
      m_rw_q     <= 1'b0;
      m_mis_q    <= 1'b0;
      m_val_q    <= '0;
      m_rd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!STALL_M) begin
        em_valid_q <= VALID_E;
        em_read_q  <= MEM_READ_E & ~MEM_WRITE_E;
        em_write_q <= MEM_WRITE_E;
        em_rw_q    <= REG_WRITE_E;
        em_alu_q   <= ALU_VAL_E;
        em_store_q <= STORE_VAL_E;
        em_f3_q    <= FUNCT3_E;
        em_rd_q    <= RD_E;
      end
      m_valid_q <= m_load;
      m_rw_q    <= m_load & em_rw_q & (em_rd_q != 5'd0) & ~em_write_q & ~em_mis;
      m_mis_q   <= m_load & em_mis;
      if (m_load) begin
        m_val_q <= (em_read_q & ~em_mis) ? load_val : em_alu_q;
        m_rd_q  <= em_rd_q;
      end
    end
  end
  assign ALU_VAL_EM  = em_alu_q;
  assign RD_VAL_M    = m_val_q;
  assign RD_M        = m_rd_q;
  assign REG_WRITE_M = m_rw_q;
  assign VALID_M     = m_valid_q;
  assign MISALIGN_M  = m_mis_q;
endmodule
